// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared state encoding and default widths for pipeline stage registers
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one clocked payload register with load enable and synchronous clear
module pipe_entry
  import cpu_pipe_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with handshake, stall, flush and optional skid entry
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  localparam int W = DATA_W + CTRL_W;

  ps_state_e      state_q;
  logic           valid_q;
  logic           skid_valid_q;
  logic           ready_q;
  logic           xfer_in;
  logic           xfer_out;
  logic           main_load;
  logic           skid_load;
  logic [W-1:0]   main_d;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;

  // Skid mode hides downstream ready behind a register; single-entry mode passes it through.
  assign ready_o  = (SKID != 0) ? ready_q : (~valid_q | (ready_i & ~stall_i));
  assign xfer_in  = valid_i & ready_o;
  assign xfer_out = valid_q & ready_i & ~stall_i;

  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = {ctrl_i, data_i};
    if (!flush_i) begin
      case (state_q)
        PS_EMPTY: main_load = xfer_in;
        PS_ONE: begin
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_in) begin
            skid_load = (SKID != 0);
          end
        end
        PS_TWO: begin
          if (xfer_out) begin
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q      <= PS_EMPTY;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (xfer_in) begin
            state_q <= PS_ONE;
            valid_q <= 1'b1;
          end
        end
        PS_ONE: begin
          if (xfer_out && !xfer_in) begin
            state_q <= PS_EMPTY;
            valid_q <= 1'b0;
          end else if (xfer_in && !xfer_out) begin
            state_q      <= PS_TWO;
            skid_valid_q <= 1'b1;
            ready_q      <= 1'b0;
          end
        end
        PS_TWO: begin
          if (xfer_out) begin
            state_q      <= PS_ONE;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q      <= PS_EMPTY;
          valid_q      <= 1'b0;
          skid_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end
      endcase
    end
  end

  pipe_entry #(.W(W)) u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(.W(W)) u_skid (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load  (skid_load),
      .d     ({ctrl_i, data_i}),
      .q     (skid_q)
    );
  end else begin : g_no_skid
    logic unused_skid_load;
    assign unused_skid_load = skid_load;
    assign skid_q           = '0;
  end

  assign valid_o = valid_q;
  assign data_o  = main_q[DATA_W-1:0];
  assign ctrl_o  = valid_q ? main_q[W-1:DATA_W] : '0;
  assign count_o = {1'b0, valid_q} + {1'b0, skid_valid_q};

endmodule
